// File: rtl/seg7_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_pkg : shared glyph constants, word type and lz helper       |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
    } word_t;

    // True when the digit at 'slot' is a leading zero: it and every digit above it are zero.
    function automatic logic lz_suppress(input logic [4*NUM_DIGITS-1:0] digits,
                                         input logic [1:0]              slot,
                                         input logic                    en);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(slot)) && (digits[i*4 +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
        return en && (slot != 2'd0) && upper_zero;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_glyph.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_glyph : 4-bit value to active-high a..g pattern             |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_DASH;
        case (value)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = GLYPH_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_scan_mux : 4-digit multiplexed 7-segment scanner with a     |
// |                 one-deep pending buffer and frame-aligned update |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV    = 1000,
    parameter int BLANK_GUARD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_digits,
    input  logic [NUM_DIGITS-1:0]   in_dp,
    input  logic                    lz_blank,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int             PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]  GUARD    = PW'(BLANK_GUARD);

    logic [PW-1:0]         pre_q,  pre_d;
    logic [1:0]            slot_q, slot_d;
    word_t                 pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    word_t                 disp_q, disp_d;
    logic [6:0]            seg_q,  seg_d;
    logic                  dp_q,   dp_d;
    logic [NUM_DIGITS-1:0] sel_q,  sel_d;
    logic                  fd_q,   fd_d;

    logic       frame_end;
    logic       guard_blank;
    logic       lz_off;
    logic [3:0] cur_digit;
    logic [6:0] cur_glyph;

    assign in_ready = !pend_full_q;

    // Scan timing and the pending/display word handoff.
    always_comb begin
        pre_d       = pre_q;
        slot_d      = slot_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;
        frame_end   = (slot_q == 2'd3) && (pre_q == PRE_LAST);

        if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            slot_d = slot_q + 2'd1;
        end else begin
            pre_d = pre_q + PW'(1);
        end

        if (frame_end && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end

        if (in_valid && in_ready) begin
            pend_d.digits = in_digits;
            pend_d.dp     = in_dp;
            pend_full_d   = 1'b1;
        end
    end

    assign cur_digit = disp_q.digits[{slot_q, 2'b00} +: 4];

    seg7_glyph u_glyph (
        .value (cur_digit),
        .glyph (cur_glyph)
    );

    // Output stage is computed from the current scan state and registered one cycle later.
    always_comb begin
        guard_blank = (pre_q < GUARD);
        lz_off      = lz_suppress(disp_q.digits, slot_q, lz_blank);
        seg_d       = GLYPH_BLANK;
        dp_d        = 1'b0;
        sel_d       = '0;
        fd_d        = frame_end;
        if (!guard_blank) begin
            sel_d = NUM_DIGITS'(1) << slot_q;
            dp_d  = disp_q.dp[slot_q];
            seg_d = lz_off ? GLYPH_BLANK : cur_glyph;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q       <= '0;
            slot_q      <= 2'd0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            disp_q      <= '0;
            seg_q       <= '0;
            dp_q        <= 1'b0;
            sel_q       <= '0;
            fd_q        <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            slot_q      <= slot_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            disp_q      <= disp_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            sel_q       <= sel_d;
            fd_q        <= fd_d;
        end
    end

    assign segments   = seg_q;
    assign dp         = dp_q;
    assign digit_sel  = sel_q;
    assign frame_done = fd_q;

endmodule
`default_nettype wire
